// File: rtl/factorial_engine_if.sv
// Host-side handshake bundle for factorial_engine: start/n request plus
// busy/done/result/ovf status. The host drives through the master modport,
// the engine attaches through the slave modport.
interface factorial_engine_if #(
  parameter int N_W   = 4,
  parameter int OUT_W = 32
);
  logic             start;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] result;
  logic             ovf;

  modport master (
    output start, n,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, n,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/factorial_engine.sv
// factorial_engine: iterative n! computation with an internal controller.
// A start seen in IDLE captures n and loads the accumulator with 1; each
// MUL cycle multiplies acc by the down-counter until the counter reaches 1,
// then DONE raises a one-cycle done pulse and the block returns to IDLE.
// Overflow of any multiply into the upper N_W product bits sets a sticky ovf.
// Optional build macro FACT_SAT_EN: saturate the accumulator to all ones on
// the first overflowing multiply instead of keeping the truncated product.
module factorial_engine #(
  parameter int N_W   = 4,
  parameter int OUT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  factorial_engine_if.slave host
);

  localparam int PROD_W = OUT_W + N_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [OUT_W-1:0]  acc;
  logic [N_W-1:0]    cnt;
  logic              ovfReg;
  logic              accept;
  logic              step;
  logic [PROD_W-1:0] product;
  logic              stepOvf;

  // Full-width product of accumulator and counter; never truncated here.
  function automatic logic [PROD_W-1:0] fullProduct(input logic [OUT_W-1:0] a,
                                                     input logic [N_W-1:0]   b);
    fullProduct = PROD_W'(a) * PROD_W'(b);
  endfunction

  // A product overflows when any bit above the accumulator width is set.
  function automatic logic productOverflows(input logic [PROD_W-1:0] p);
    productOverflows = |p[PROD_W-1:OUT_W];
  endfunction

`ifdef FACT_SAT_EN
  // Clamp to all ones once this run has overflowed, so the value stays
  // pinned even as counting continues.
  function automatic logic [OUT_W-1:0] nextAcc(input logic [PROD_W-1:0] p,
                                               input logic              ovfSoFar);
    if (ovfSoFar || productOverflows(p)) nextAcc = '1;
    else                                 nextAcc = p[OUT_W-1:0];
  endfunction
`else
  // Wrap-around: keep the low OUT_W bits and keep iterating on them.
  function automatic logic [OUT_W-1:0] nextAcc(input logic [PROD_W-1:0] p);
    nextAcc = p[OUT_W-1:0];
  endfunction
`endif

  // Multiplier datapath and per-step overflow detect.
  always_comb begin
    product = fullProduct(acc, cnt);
    stepOvf = productOverflows(product);
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic, datapath enables and handshake outputs.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    step      = 1'b0;
    host.busy = 1'b1;
    host.done = 1'b0;
    unique case (state)
      IDLE: begin
        host.busy = 1'b0;
        if (host.start) begin
          accept    = 1'b1;
          stateNext = MUL;
        end
      end
      MUL: begin
        // Unsigned compare: n=0 falls straight through like n=1.
        if (cnt > N_W'(1)) step = 1'b1;
        else               stateNext = DONE;
      end
      DONE: begin
        host.done = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Accumulator, down-counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      ovfReg <= 1'b0;
    end else if (accept) begin
      acc    <= OUT_W'(1);
      cnt    <= host.n;
      ovfReg <= 1'b0;
    end else if (step) begin
`ifdef FACT_SAT_EN
      acc    <= nextAcc(product, ovfReg);
`else
      acc    <= nextAcc(product);
`endif
      cnt    <= cnt - N_W'(1);
      ovfReg <= ovfReg | stepOvf;
    end
  end

  // Result mirrors the accumulator so it holds between runs.
  always_comb begin
    host.result = acc;
    host.ovf    = ovfReg;
  end

`ifndef SYNTHESIS
  // done is a single-cycle pulse.
  a_donePulse: assert property (@(posedge clk) disable iff (!rst_n)
    host.done |=> !host.done);
  // done only ever appears while busy.
  a_doneBusy: assert property (@(posedge clk) disable iff (!rst_n)
    host.done |-> host.busy);
`endif

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine: directed corner runs, random
// runs against a step-by-step arithmetic model, busy/back-to-back/reset
// handling, and a second 64-bit instance for the wide configuration.
module tb_factorial_engine;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFail;

  factorial_engine_if #(.N_W(4), .OUT_W(32)) bus ();
  factorial_engine_if #(.N_W(4), .OUT_W(64)) bus64 ();

  factorial_engine #(.N_W(4), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus)
  );

  factorial_engine #(.N_W(4), .OUT_W(64)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: n! formed as n*(n-1)*...*2, each step reduced to outW bits,
  // overflow whenever the exact step product does not fit in outW bits.
  function automatic void model(input int nVal, input int outW,
                                output logic [127:0] res, output bit ovfOut);
    logic [127:0] mask;
    logic [127:0] acc;
    logic [127:0] full;
    mask   = (128'd1 << outW) - 128'd1;
    acc    = 128'd1;
    ovfOut = 1'b0;
    for (int k = nVal; k > 1; k--) begin
      full = acc * 128'(k);
      if ((full >> outW) != 128'd0) ovfOut = 1'b1;
`ifdef FACT_SAT_EN
      if (ovfOut) acc = mask;
      else        acc = full & mask;
`else
      acc = full & mask;
`endif
    end
    res = acc;
  endfunction

  function automatic int expCycles(input int nVal);
    expCycles = (nVal < 1 ? 1 : nVal) + 1;
  endfunction

  // Pulse start for one cycle from IDLE, then wait (bounded) for done.
  // cyc is the cycle in which done appeared (accept edge opens cycle 1),
  // or 0 on timeout; busyOk drops if busy was low before done.
  task automatic runOnce(input logic [3:0] nVal, output int cyc, output bit busyOk);
    @(negedge clk);
    bus.n     = nVal;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc    = 1;
    busyOk = 1'b1;
    while (bus.done !== 1'b1 && cyc < 64) begin
      if (bus.busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL reset_done got %b want 0", bus.done); end
    nChecks++; if (bus.ovf !== 1'b0) begin nFail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    nChecks++; if (bus.result !== 32'd0) begin nFail++; $display("FAIL reset_result got %0d want 0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    bit busyOk;
    runOnce(4'd5, cyc, busyOk);
    nChecks++; if (cyc != 6) begin nFail++; $display("FAIL basic_latency got %0d want 6", cyc); end
    nChecks++; if (!busyOk) begin nFail++; $display("FAIL basic_busy got low want high before done"); end
    nChecks++; if (bus.result !== 32'd120) begin nFail++; $display("FAIL basic_result got %0d want 120", bus.result); end
    nChecks++; if (bus.ovf !== 1'b0) begin nFail++; $display("FAIL basic_ovf got %b want 0", bus.ovf); end
    @(posedge clk); #1;
    nChecks++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    nChecks++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (bus.result !== 32'd120) begin nFail++; $display("FAIL basic_hold got %0d want 120", bus.result); end
  endtask

  task automatic test_corners();
    logic [3:0]  nList [4] = '{4'd0, 4'd1, 4'd12, 4'd13};
    logic [31:0] rList [4];
    bit          oList [4];
    int cyc;
    bit busyOk;
    rList[0] = 32'd1;
    rList[1] = 32'd1;
    rList[2] = 32'd479001600;
    oList[0] = 1'b0;
    oList[1] = 1'b0;
    oList[2] = 1'b0;
    oList[3] = 1'b1;
`ifdef FACT_SAT_EN
    rList[3] = 32'hFFFF_FFFF;
`else
    rList[3] = 32'h7328_CC00;
`endif
    for (int i = 0; i < 4; i++) begin
      runOnce(nList[i], cyc, busyOk);
      nChecks++; if (cyc != expCycles(int'(nList[i]))) begin nFail++; $display("FAIL corner_latency n=%0d got %0d want %0d", nList[i], cyc, expCycles(int'(nList[i]))); end
      nChecks++; if (bus.result !== rList[i]) begin nFail++; $display("FAIL corner_result n=%0d got %0d want %0d", nList[i], bus.result, rList[i]); end
      nChecks++; if (bus.ovf !== oList[i]) begin nFail++; $display("FAIL corner_ovf n=%0d got %b want %b", nList[i], bus.ovf, oList[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [127:0] expRes;
    bit expOvf;
    logic [3:0] nVal;
    int cyc;
    bit busyOk;
    for (int i = 0; i < 24; i++) begin
      nVal = 4'($urandom_range(0, 15));
      model(int'(nVal), 32, expRes, expOvf);
      runOnce(nVal, cyc, busyOk);
      nChecks++; if (cyc != expCycles(int'(nVal))) begin nFail++; $display("FAIL rand_latency n=%0d got %0d want %0d", nVal, cyc, expCycles(int'(nVal))); end
      nChecks++; if (bus.result !== expRes[31:0]) begin nFail++; $display("FAIL rand_result n=%0d got %h want %h", nVal, bus.result, expRes[31:0]); end
      nChecks++; if (bus.ovf !== expOvf) begin nFail++; $display("FAIL rand_ovf n=%0d got %b want %b", nVal, bus.ovf, expOvf); end
      nChecks++; if (!busyOk) begin nFail++; $display("FAIL rand_busy n=%0d got low want high", nVal); end
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    bus.n     = 4'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    bus.n     = 4'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    nChecks++; if (cyc != 10) begin nFail++; $display("FAIL busy_ignore_latency got %0d want 10", cyc); end
    nChecks++; if (bus.result !== 32'd362880) begin nFail++; $display("FAIL busy_ignore_result got %0d want 362880", bus.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    bus.n     = 4'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    nChecks++; if (bus.result !== 32'd6) begin nFail++; $display("FAIL b2b_first got %0d want 6", bus.result); end
    @(posedge clk); #1;
    nChecks++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL b2b_gap_busy got %b want 0", bus.busy); end
    bus.n = 4'd4;
    @(posedge clk); #1;
    nChecks++; if (bus.busy !== 1'b1) begin nFail++; $display("FAIL b2b_reaccept got %b want 1", bus.busy); end
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    nChecks++; if (cyc != 5) begin nFail++; $display("FAIL b2b_latency got %0d want 5", cyc); end
    nChecks++; if (bus.result !== 32'd24) begin nFail++; $display("FAIL b2b_second got %0d want 24", bus.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit busyOk;
    @(negedge clk);
    bus.n     = 4'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nChecks++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    nChecks++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL midrst_done got %b want 0", bus.done); end
    nChecks++; if (bus.ovf !== 1'b0) begin nFail++; $display("FAIL midrst_ovf got %b want 0", bus.ovf); end
    nChecks++; if (bus.result !== 32'd0) begin nFail++; $display("FAIL midrst_result got %0d want 0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    runOnce(4'd6, cyc, busyOk);
    nChecks++; if (bus.result !== 32'd720) begin nFail++; $display("FAIL midrst_rerun got %0d want 720", bus.result); end
    nChecks++; if (cyc != 7) begin nFail++; $display("FAIL midrst_latency got %0d want 7", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    logic [127:0] expRes;
    bit expOvf;
    int cyc;
    model(15, 64, expRes, expOvf);
    @(negedge clk);
    bus64.n     = 4'd15;
    bus64.start = 1'b1;
    @(posedge clk); #1;
    bus64.start = 1'b0;
    cyc = 1;
    while (bus64.done !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    nChecks++; if (cyc != 16) begin nFail++; $display("FAIL wide_latency got %0d want 16", cyc); end
    nChecks++; if (bus64.result !== 64'd1307674368000) begin nFail++; $display("FAIL wide_result got %0d want 1307674368000", bus64.result); end
    nChecks++; if (bus64.result !== expRes[63:0]) begin nFail++; $display("FAIL wide_model got %0d want %0d", bus64.result, expRes[63:0]); end
    nChecks++; if (bus64.ovf !== 1'b0) begin nFail++; $display("FAIL wide_ovf got %b want 0", bus64.ovf); end
    @(posedge clk); #1;
  endtask

  initial begin
    nChecks     = 0;
    nFail       = 0;
    bus.start   = 1'b0;
    bus.n       = '0;
    bus64.start = 1'b0;
    bus64.n     = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
